uart_tx_drain: RTL and testbench
================================

Name: uart_tx_drain

Overview:
- Serial transmitter that sits directly downstream of the byte-wide first-word-fall-through FIFO.
- Pops one DATA_WIDTH word whenever the FIFO is non-empty and transmission is enabled, then shifts it out as an asynchronous serial frame: start bit, data LSB first, optional even parity, stop bit(s).
- Bit timing comes from an internal clocks-per-bit counter. Back-to-back frames are sent with no idle gap while data remains.

Parameters:
- DATA_WIDTH, 8, width of the FIFO read word and number of data bits per frame (1..16).
- CLKS_PER_BIT, 16, clk cycles each serial bit is held (>=2).
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset. Sampled only on rising clk edge; reset==0 resets.
- en  input  1  allows new words to be popped; does not abort a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty==0 (FWFT).
- fifo_rd  output  1  one-cycle pop strobe to the FIFO rd input.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line.
- tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; bit counter, cycle counter and shift register clear.
  - tx=1, busy=0, tx_done=0.
  - fifo_rd is forced 0 in any cycle where reset==0.
- States: IDLE, START, DATA, PARITY, STOP.
- load condition: en && !fifo_empty && (state==IDLE || last cycle of final stop bit).
- fifo_rd is combinational and equals load (gated by reset==1).
- On the edge where load is true:
  - fifo_data is captured into the shift register.
  - The parity bit is computed as the XOR of the captured bits.
  - State goes to START and the cycle counter resets to 0.
  - The FIFO pops on that same edge.
- Each of START, DATA bits, PARITY and STOP bits holds tx for exactly CLKS_PER_BIT cycles. Advance occurs when the cycle counter reaches CLKS_PER_BIT-1.
- tx is registered:
  - START drives 0.
  - DATA drives shift register bit 0, shifting right each bit; DATA_WIDTH bits total.
  - PARITY drives the even-parity bit and is skipped when PARITY_EN==0.
  - STOP drives 1 for STOP_BITS bit periods.
- Latency: tx falls on the first cycle after the load edge.
- Frame length = (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- busy is 1 in START/DATA/PARITY/STOP and 0 in IDLE.
- tx_done is 1 only on the last STOP cycle.
- End of frame:
  - If load is true on the last STOP cycle, the next frame's START begins on the next cycle. tx_done and fifo_rd coincide, there is no idle cycle, and busy stays 1.
  - Otherwise the block returns to IDLE.
- en deasserted mid-frame: the current frame completes normally and no further pop occurs.
- fifo_empty rising mid-frame: no effect on the current frame.
- Reset mid-frame: the frame is aborted immediately, tx returns to 1 on that edge, and the popped word is discarded.
- In IDLE, tx=1. fifo_data is ignored whenever load is false.
- Counters are sized to ceil(log2(CLKS_PER_BIT)) and ceil(log2(DATA_WIDTH+1)) bits; no wrap beyond terminal count.

Test Plan:
- Reset: hold reset=0 for 3 cycles with fifo_empty=0 and en=1 -> fifo_rd=0, tx=1, busy=0, tx_done=0 throughout. First pop occurs on the first edge with reset=1.
- Single word, DATA_WIDTH=8, CLKS_PER_BIT=4, no parity, STOP_BITS=1, fifo_data=0xA5 -> fifo_rd high for exactly 1 cycle. tx bit periods are 0,1,0,1,0,0,1,0,1,1, 4 cycles each, 40 cycles total. tx_done pulses on cycle 40, then IDLE with tx=1.
- Back-to-back: FIFO holds 0x00 then 0xFF with en=1 -> second fifo_rd coincides with the first tx_done. tx goes low the next cycle with no idle gap and busy stays 1. Exactly 2 pops, then idle.
- Parity: PARITY_EN=1, data 0x07 -> parity bit period drives 1. Data 0x03 -> parity bit period drives 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- Reset mid-frame: assert reset=0 during data bit 3 -> tx=1 and busy=0 after that edge. After release with the FIFO non-empty, a fresh frame starts with a new pop.
- Enable gating:
  - en=0 with fifo_empty=0 for 20 cycles -> no fifo_rd, tx=1.
  - Drop en during a frame -> that frame completes, and no pop occurs on its last STOP cycle.

Source files
------------

// File: rtl/uart_tx_drain.sv
// Serial transmitter fed by a first-word-fall-through FIFO: pops a word whenever
// allowed and sends start bit, data LSB first, optional even parity and stop bit(s).
module uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cyc_reg, cyc_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  parity_reg, parity_next;
  logic                  tx_reg, tx_next;
  logic                  bit_end;
  logic                  frame_end;
  logic                  load;

  assign bit_end   = (cyc_reg == CYC_LAST);
  assign frame_end = (state_reg == STOP) && bit_end && (bit_reg == STOP_LAST);
  // A new word may be taken from idle or on the very last stop cycle, so
  // back-to-back frames follow each other with no gap.
  assign load      = reset && en && !fifo_empty && ((state_reg == IDLE) || frame_end);

  assign fifo_rd = load;
  assign tx      = tx_reg;
  assign busy    = (state_reg != IDLE);
  assign tx_done = frame_end;

  always_comb begin
    state_next  = state_reg;
    cyc_next    = bit_end ? '0 : cyc_reg + 1'b1;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;

    if (load) begin
      state_next  = START;
      cyc_next    = '0;
      bit_next    = '0;
      shift_next  = fifo_data;
      parity_next = ^fifo_data;
      tx_next     = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          cyc_next = '0;
          tx_next  = 1'b1;
        end
        START: begin
          if (bit_end) begin
            state_next = DATA;
            bit_next   = '0;
            tx_next    = shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_reg == DATA_LAST) begin
              bit_next = '0;
              if (PARITY_EN != 0) begin
                state_next = PARITY;
                tx_next    = parity_reg;
              end else begin
                state_next = STOP;
                tx_next    = 1'b1;
              end
            end else begin
              bit_next   = bit_reg + 1'b1;
              shift_next = shift_reg >> 1;
              tx_next    = shift_next[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_next = STOP;
            bit_next   = '0;
            tx_next    = 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_reg == STOP_LAST) begin
              state_next = IDLE;
              bit_next   = '0;
              tx_next    = 1'b1;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cyc_next   = '0;
          bit_next   = '0;
          tx_next    = 1'b1;
        end
      endcase
    end
  end

  // Reset aborts any frame in flight; the word already popped is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cyc_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: one instance without parity and one with, each fed by
// its own FIFO model and checked against a frame-position reference model.
module tb_uart_tx_drain;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          en    = 1'b0;
  logic          fifo_empty [2];
  logic [DW-1:0] fifo_data  [2];
  logic          fifo_rd    [2];
  logic          tx         [2];
  logic          busy       [2];
  logic          tx_done    [2];

  logic [DW-1:0] mem [2][64];
  int            wr [2] = '{0, 0};
  int            rd [2] = '{0, 0};
  int            m_pos [2] = '{-1, -1};
  logic [DW-1:0] m_word [2];
  logic          exp_rd [2];
  logic          exp_tx [2];
  logic          exp_busy [2];
  logic          exp_done [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      uart_tx_drain #(
        .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(gi), .STOP_BITS(1)
      ) u_dut (
        .clk(clk), .reset(reset), .en(en),
        .fifo_empty(fifo_empty[gi]), .fifo_data(fifo_data[gi]),
        .fifo_rd(fifo_rd[gi]), .tx(tx[gi]), .busy(busy[gi]), .tx_done(tx_done[gi])
      );
    end
  endgenerate

  function automatic int flen(input int d);
    return (1 + DW + d + 1) * CPB;
  endfunction

  // Line level at cycle pos of a frame carrying word w
  function automatic logic frame_bit(input int d, input logic [DW-1:0] w, input int pos);
    int b;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (d == 1 && b == DW + 1) return ^w;
    return 1'b1;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      fifo_empty[d] = (wr[d] == rd[d]);
      fifo_data[d]  = mem[d][rd[d] % 64];
      exp_busy[d]   = (m_pos[d] >= 0);
      exp_done[d]   = (m_pos[d] == flen(d) - 1);
      exp_tx[d]     = (m_pos[d] >= 0) ? frame_bit(d, m_word[d], m_pos[d]) : 1'b1;
      exp_rd[d]     = reset && en && (wr[d] != rd[d]) && ((m_pos[d] < 0) || exp_done[d]);
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (fifo_rd[d] === 1'b1) rd[d] <= rd[d] + 1;
      if (!reset) m_pos[d] <= -1;
      else if (exp_rd[d]) begin
        m_word[d] <= fifo_data[d];
        m_pos[d]  <= 0;
      end else if (m_pos[d] >= 0) m_pos[d] <= exp_done[d] ? -1 : m_pos[d] + 1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    for (int d = 0; d < 2; d++) begin
      mem[d][wr[d] % 64] = w;
      wr[d] = wr[d] + 1;
    end
  endtask

  function automatic logic all_idle();
    return (wr[0] == rd[0]) && (wr[1] == rd[1]) && (m_pos[0] < 0) && (m_pos[1] < 0)
           && (busy[0] === 1'b0) && (busy[1] === 1'b0);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b1;
    push(8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== 4'b0100) begin
          errors++;
          $display("FAIL reset_hold dut%0d rd,tx,busy,done got %b%b%b%b want 0100",
                   d, fifo_rd[d], tx[d], busy[d], tx_done[d]);
        end
      end
    end
    reset = 1'b1; #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fifo_rd[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_first_pop dut%0d fifo_rd got %b want 1", d, fifo_rd[d]);
      end
    end
    for (int n = 0; n < 200 && !all_idle(); n++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL reset_drain dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
    end
    checks++;
    if (!all_idle()) begin errors++; $display("FAIL reset_drain_timeout busy got 1 want 0"); end
  endtask

  task automatic test_single();
    logic       tx_hist [60];
    logic [9:0] seq;
    int         pop_n, done_n, pops;
    seq = 10'b1101001010;
    pop_n = -1; done_n = -1; pops = 0;
    push(8'hA5); #1;
    for (int n = 0; n < 60; n++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL single dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
      tx_hist[n] = tx[0];
      if (fifo_rd[0] === 1'b1) begin pops++; pop_n = n; end
      if (tx_done[0] === 1'b1) done_n = n;
      @(negedge clk); #1;
    end
    checks++;
    if (pops !== 1) begin errors++; $display("FAIL single_pops got %0d want 1", pops); end
    checks++;
    if (done_n - pop_n !== 40) begin
      errors++; $display("FAIL single_length got %0d want 40", done_n - pop_n);
    end
    if (pop_n >= 0 && pop_n + 41 < 60) begin
      for (int b = 0; b < 10; b++) begin
        checks++;
        if (tx_hist[pop_n + 1 + 4*b + 2] !== seq[b]) begin
          errors++;
          $display("FAIL single_bit%0d tx got %b want %b", b, tx_hist[pop_n + 1 + 4*b + 2], seq[b]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pops, seen_done, gap_check;
    pops = 0; seen_done = 0; gap_check = 0;
    push(8'h00); push(8'hFF); #1;
    for (int n = 0; n < 120; n++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL b2b dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
      if (gap_check == 1) begin
        checks++;
        if ({busy[0], tx[0]} !== 2'b10) begin
          errors++; $display("FAIL b2b_no_gap busy,tx got %b%b want 10", busy[0], tx[0]);
        end
        gap_check = 2;
      end
      if (fifo_rd[0] === 1'b1) pops++;
      if (tx_done[0] === 1'b1 && seen_done == 0) begin
        seen_done = 1;
        gap_check = 1;
        checks++;
        if (fifo_rd[0] !== 1'b1) begin
          errors++; $display("FAIL b2b_rd_with_done fifo_rd got %b want 1", fifo_rd[0]);
        end
      end
      @(negedge clk); #1;
    end
    checks++;
    if (pops !== 2 || gap_check != 2) begin
      errors++; $display("FAIL b2b_pops got %0d want 2 (gap_check %0d)", pops, gap_check);
    end
  endtask

  task automatic test_parity();
    logic tx_hist [120];
    int   pop_at [2];
    int   pops;
    pops = 0;
    push(8'h07); push(8'h03); #1;
    for (int n = 0; n < 120; n++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL parity dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
      tx_hist[n] = tx[1];
      if (fifo_rd[1] === 1'b1 && pops < 2) begin pop_at[pops] = n; pops++; end
      @(negedge clk); #1;
    end
    checks++;
    if (pops !== 2) begin
      errors++; $display("FAIL parity_pops got %0d want 2", pops);
    end else begin
      checks++;
      if (pop_at[1] - pop_at[0] !== 44) begin
        errors++; $display("FAIL parity_length got %0d want 44", pop_at[1] - pop_at[0]);
      end
      checks++;
      if (tx_hist[pop_at[0] + 38] !== 1'b1) begin
        errors++; $display("FAIL parity_bit_07 tx got %b want 1", tx_hist[pop_at[0] + 38]);
      end
      if (pop_at[1] + 38 < 120) begin
        checks++;
        if (tx_hist[pop_at[1] + 38] !== 1'b0) begin
          errors++; $display("FAIL parity_bit_03 tx got %b want 0", tx_hist[pop_at[1] + 38]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    push(8'h5A); push(8'hC3); #1;
    for (int n = 0; n < 19; n++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL rst_mid dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
      if (n < 18) begin @(negedge clk); #1; end
    end
    reset = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fifo_rd[d] !== 1'b0) begin
        errors++; $display("FAIL rst_mid_rd_low dut%0d fifo_rd got %b want 0", d, fifo_rd[d]);
      end
    end
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({tx[d], busy[d]} !== 2'b10) begin
        errors++; $display("FAIL rst_mid_abort dut%0d tx,busy got %b%b want 10", d, tx[d], busy[d]);
      end
    end
    reset = 1'b1; #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fifo_rd[d] !== 1'b1) begin
        errors++; $display("FAIL rst_mid_new_pop dut%0d fifo_rd got %b want 1", d, fifo_rd[d]);
      end
    end
    for (int n = 0; n < 200 && !all_idle(); n++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL rst_mid_drain dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
    end
    checks++;
    if (!all_idle()) begin errors++; $display("FAIL rst_mid_timeout busy got 1 want 0"); end
  endtask

  task automatic test_enable();
    int pops, seen_done;
    pops = 0; seen_done = 0;
    en = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); #1;
    for (int n = 0; n < 20; n++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d]} !== 2'b01) begin
          errors++; $display("FAIL en_off_idle dut%0d rd,tx got %b%b want 01", d, fifo_rd[d], tx[d]);
        end
      end
      @(negedge clk); #1;
    end
    en = 1'b1; #1;
    for (int n = 0; n < 70; n++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL en_drop dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
      if (fifo_rd[0] === 1'b1) pops++;
      if (tx_done[0] === 1'b1) begin
        seen_done = 1;
        checks++;
        if (fifo_rd[0] !== 1'b0) begin
          errors++; $display("FAIL en_drop_done_no_pop fifo_rd got %b want 0", fifo_rd[0]);
        end
      end
      if (m_pos[0] == 10) en = 1'b0;
      @(negedge clk); #1;
    end
    checks++;
    if (pops !== 1 || seen_done != 1) begin
      errors++; $display("FAIL en_drop_pops got %0d want 1 (done seen %0d)", pops, seen_done);
    end
    en = 1'b1; #1;
    for (int n = 0; n < 300 && !all_idle(); n++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL en_drain dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
    end
    checks++;
    if (!all_idle()) begin errors++; $display("FAIL en_drain_timeout busy got 1 want 0"); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL random dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
      if ($urandom_range(0, 3) == 0 && (wr[0] - rd[0]) < 40 && (wr[1] - rd[1]) < 40)
        push(DW'($urandom));
      en = ($urandom_range(0, 7) != 0);
      @(negedge clk); #1;
    end
    en = 1'b1; #1;
    for (int n = 0; n < 3000 && !all_idle(); n++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({fifo_rd[d], tx[d], busy[d], tx_done[d]} !== {exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]}) begin
          errors++;
          $display("FAIL random_drain dut%0d t=%0t rd,tx,busy,done got %b%b%b%b want %b%b%b%b", d, $time,
                   fifo_rd[d], tx[d], busy[d], tx_done[d], exp_rd[d], exp_tx[d], exp_busy[d], exp_done[d]);
        end
      end
    end
    checks++;
    if (!all_idle()) begin errors++; $display("FAIL random_timeout busy got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    $display("test_reset done: errors=%0d", errors);
    test_single();
    $display("test_single done: errors=%0d", errors);
    test_back_to_back();
    $display("test_back_to_back done: errors=%0d", errors);
    test_parity();
    $display("test_parity done: errors=%0d", errors);
    test_reset_mid();
    $display("test_reset_mid done: errors=%0d", errors);
    test_enable();
    $display("test_enable done: errors=%0d", errors);
    test_random();
    $display("test_random done: errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
